// File: rtl/draw_pkg.sv
// Shared constants and types for the sprite draw engine.
// Optional build macro: TRANSPARENT_EN (colour-key transparency).
package draw_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;
  localparam int DEF_ADDR_W  = 15;
  localparam int SPRITE_SIZE = 40;

  localparam logic [2:0] BLACK       = 3'b000;
  localparam logic [2:0] KEY_MAGENTA = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    FIN
  } drawState_t;

endpackage

// File: rtl/sprite_draw_engine_if.sv
// Command, ROM and VGA signals of the sprite draw engine.
// master = game controller side, slave = draw engine.
// Optional build macro: TRANSPARENT_EN adds colourKey.
interface sprite_draw_engine_if
  import draw_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              start;
  logic              black;
  logic [7:0]        xOrigin;
  logic [6:0]        yOrigin;
  logic [7:0]        width;
  logic [6:0]        height;
  logic [2:0]        romData;
`ifdef TRANSPARENT_EN
  logic [2:0]        colourKey;
`endif
  logic [ADDR_W-1:0] romAddr;
  logic [7:0]        vgaX;
  logic [6:0]        vgaY;
  logic [2:0]        vgaColour;
  logic              plot;
  logic              busy;
  logic              done;

  modport master (
    output start, black, xOrigin, yOrigin, width, height, romData,
`ifdef TRANSPARENT_EN
    output colourKey,
`endif
    input  romAddr, vgaX, vgaY, vgaColour, plot, busy, done
  );

  modport slave (
    input  start, black, xOrigin, yOrigin, width, height, romData,
`ifdef TRANSPARENT_EN
    input  colourKey,
`endif
    output romAddr, vgaX, vgaY, vgaColour, plot, busy, done
  );

endinterface

// File: rtl/draw_delay_line.sv
// STAGES-deep shift register carrying a valid bit and a data word.
// Only the valid bits are reset; data simply follows.
module draw_delay_line #(
  parameter int STAGES = 1,
  parameter int DATA_W = 17
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              vldIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic              vldOut,
  output logic [DATA_W-1:0] dataOut
);

  logic [STAGES-1:0] vldPipe;
  logic [DATA_W-1:0] dataPipe [STAGES];

  // Valid bits shift with synchronous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vldPipe <= '0;
    end else begin
      vldPipe[0] <= vldIn;
      for (int i = 1; i < STAGES; i++) vldPipe[i] <= vldPipe[i-1];
    end
  end

  // Data words shift alongside their valid bits.
  always_ff @(posedge clk) begin
    dataPipe[0] <= dataIn;
    for (int i = 1; i < STAGES; i++) dataPipe[i] <= dataPipe[i-1];
  end

  assign vldOut  = vldPipe[STAGES-1];
  assign dataOut = dataPipe[STAGES-1];

endmodule

// File: rtl/sprite_draw_engine.sv
// Raster-scans a rectangle, issuing ROM addresses and aligned VGA pixels.
// Optional build macro: TRANSPARENT_EN suppresses pixels equal to colourKey.
module sprite_draw_engine
  import draw_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ROM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sprite_draw_engine_if.slave  bus
);

  localparam logic [1:0] FLUSH_LAST = 2'(ROM_LAT);

  drawState_t        state, nextState;
  logic [7:0]        xOrgL, widthL, col;
  logic [6:0]        yOrgL, heightL, row;
  logic              blackL;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        flushCnt;
  logic              lastPix, zeroSize, keyHit, pixOk;
  logic              vld_p0, vld_p1;
  logic [8:0]        xPix_p0, xPix_p1;
  logic [7:0]        yPix_p0, yPix_p1;
  logic [7:0]        vgaXR;
  logic [6:0]        vgaYR;
  logic [2:0]        colourR;
  logic              plotR, doneR;

  function automatic logic inScreen(input logic [8:0] x, input logic [7:0] y);
    return (x < 9'(SCREEN_W)) && (y < 8'(SCREEN_H));
  endfunction

  assign lastPix  = (col == widthL - 8'd1) && (row == heightL - 7'd1);
  assign zeroSize = (bus.width == 8'd0) || (bus.height == 7'd0);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= nextState;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start) nextState = zeroSize ? FIN : SCAN;
      SCAN:    if (lastPix) nextState = FLUSH;
      FLUSH:   if (flushCnt == FLUSH_LAST) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Latch geometry and the black flag when a draw is accepted.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      xOrgL   <= bus.xOrigin;
      yOrgL   <= bus.yOrigin;
      widthL  <= bus.width;
      heightL <= bus.height;
      blackL  <= bus.black;
    end
  end

  // Column/row walk with an incremental linear address; flush timer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      col      <= '0;
      row      <= '0;
      addr     <= '0;
      flushCnt <= '0;
    end else begin
      unique case (state)
        IDLE: if (bus.start) begin
          col  <= '0;
          row  <= '0;
          addr <= '0;
        end
        SCAN: begin
          flushCnt <= '0;
          if (!lastPix) addr <= addr + ADDR_W'(1);
          if (col == widthL - 8'd1) begin
            col <= '0;
            row <= row + 7'd1;
          end else begin
            col <= col + 8'd1;
          end
        end
        FLUSH:   flushCnt <= flushCnt + 2'd1;
        default: ;
      endcase
    end
  end

  // Stage p0: pixel coordinates of the address being issued, unclipped.
  assign vld_p0  = (state == SCAN);
  assign xPix_p0 = 9'(xOrgL) + 9'(col);
  assign yPix_p0 = 8'(yOrgL) + 8'(row);

  draw_delay_line #(
    .STAGES (ROM_LAT),
    .DATA_W (17)
  ) u_delay (
    .clk     (clk),
    .resetn  (resetn),
    .vldIn   (vld_p0),
    .dataIn  ({xPix_p0, yPix_p0}),
    .vldOut  (vld_p1),
    .dataOut ({xPix_p1, yPix_p1})
  );

  // Stage p1: coordinates now line up with romData.
`ifdef TRANSPARENT_EN
  assign keyHit = !blackL && (bus.romData == bus.colourKey);
`else
  assign keyHit = 1'b0;
`endif
  assign pixOk = vld_p1 && inScreen(xPix_p1, yPix_p1) && !keyHit;

  // Registered VGA outputs; coordinates and colour hold when not plotting.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      plotR   <= 1'b0;
      doneR   <= 1'b0;
      vgaXR   <= '0;
      vgaYR   <= '0;
      colourR <= '0;
    end else begin
      plotR <= pixOk;
      doneR <= (state == FIN);
      if (pixOk) begin
        vgaXR   <= xPix_p1[7:0];
        vgaYR   <= yPix_p1[6:0];
        colourR <= blackL ? BLACK : bus.romData;
      end
    end
  end

  assign bus.romAddr   = addr;
  assign bus.vgaX      = vgaXR;
  assign bus.vgaY      = vgaYR;
  assign bus.vgaColour = colourR;
  assign bus.plot      = plotR;
  assign bus.done      = doneR;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed, table-driven bench for sprite_draw_engine (ROM_LAT = 1).
// With TRANSPARENT_EN defined it also exercises colour-key transparency.
module tb_sprite_draw_engine;
  import draw_pkg::*;

  localparam int ROM_LAT = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sprite_draw_engine_if #(.ADDR_W(DEF_ADDR_W)) bus();

  sprite_draw_engine #(
    .ADDR_W  (DEF_ADDR_W),
    .ROM_LAT (ROM_LAT)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int errors = 0;
  int checks = 0;
  int romMode = 0;
  logic [2:0] romQ;

  // ROM contents: mode 0 -> addr[2:0]; mode 1 -> 5 on even, 2 on odd addresses.
  function automatic logic [2:0] romFn(input int mode, input int a);
    if (mode == 0) return a[2:0];
    return (a % 2 == 0) ? 3'd5 : 3'd2;
  endfunction

  always @(posedge clk) romQ <= romFn(romMode, int'(bus.romAddr));
  assign bus.romData = romQ;

  typedef struct {
    int xo, yo, w, h, blk, glitch;
    int expPlots, expDone, expAddr, expFirst, lastX, lastY;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit pixPlots(input vec_t v, input int k, input int keyOn, input int key);
    int x, y;
    x = v.xo + k % v.w;
    y = v.yo + k / v.w;
    if (x >= SCREEN_W || y >= SCREEN_H) return 0;
    if (keyOn != 0 && v.blk == 0 && int'(romFn(romMode, k)) == key) return 0;
    return 1;
  endfunction

  task automatic runDraw(input vec_t v, input int keyOn, input int key, input string tag);
    int cyc, plots, pixErr, doneCyc, doneCnt, k, firstCyc, busy1, n, lim;
    int ex, ey, ec;
    n = v.w * v.h;
    k = 0; plots = 0; pixErr = 0; doneCyc = -1; doneCnt = 0; firstCyc = -1; busy1 = 0;
    lim = n + 40;
    @(negedge clk);
    bus.xOrigin = 8'(v.xo);
    bus.yOrigin = 7'(v.yo);
    bus.width   = 8'(v.w);
    bus.height  = 7'(v.h);
    bus.black   = v.blk[0];
    bus.start   = 1'b1;
    cyc = 0;
    while (cyc < lim && doneCyc < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus.start = 1'b0;
        busy1 = int'(bus.busy);
      end
      if (v.glitch != 0 && cyc == v.glitch) begin
        bus.start = 1'b1; bus.xOrigin = 8'd0; bus.width = 8'd3; bus.height = 7'd2;
      end else if (v.glitch != 0 && cyc == v.glitch + 1) begin
        bus.start = 1'b0;
      end
      if (bus.plot) begin
        if (plots == 0) firstCyc = cyc;
        while (k < n && !pixPlots(v, k, keyOn, key)) k++;
        if (k >= n) begin
          pixErr++;
        end else begin
          ex = v.xo + k % v.w;
          ey = v.yo + k / v.w;
          ec = (v.blk != 0) ? 0 : int'(romFn(romMode, k));
          if (int'(bus.vgaX) != ex || int'(bus.vgaY) != ey || int'(bus.vgaColour) != ec) pixErr++;
          k++;
        end
        plots++;
      end
      if (bus.done) begin
        doneCyc = cyc;
        doneCnt++;
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.done) doneCnt++;
      if (bus.plot) plots++;
    end
    check({tag, " plots"}, plots, v.expPlots);
    check({tag, " pixel errors"}, pixErr, 0);
    check({tag, " done cycle"}, doneCyc, v.expDone);
    check({tag, " done pulses"}, doneCnt, 1);
    check({tag, " busy after start"}, busy1, 1);
    check({tag, " busy after done"}, int'(bus.busy), 0);
    check({tag, " final romAddr"}, int'(bus.romAddr), v.expAddr);
    if (v.expPlots > 0) begin
      check({tag, " first plot cycle"}, firstCyc, v.expFirst);
      check({tag, " last vgaX"}, int'(bus.vgaX), v.lastX);
      check({tag, " last vgaY"}, int'(bus.vgaY), v.lastY);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    //            xo   yo   w    h   blk glt plots  done   addr  1st lx  ly
    vecs[0] = '{  0,   0, 160, 120,  0,  0, 19200, 19204, 19199, 3, 159, 119};
    vecs[1] = '{ 60,  40,  40,  40,  0,  0,  1600,  1604,  1599, 3,  99,  79};
    vecs[2] = '{150, 100,  40,  40,  0,  0,   200,  1604,  1599, 3, 159, 119};
    vecs[3] = '{ 10,  10,  40,  40,  1,  0,  1600,  1604,  1599, 3,  49,  49};
    vecs[4] = '{  5,   5,   0,  10,  0,  0,     0,     2,     0, 0,   0,   0};
    vecs[5] = '{  5,   5,  10,   0,  0,  0,     0,     2,     0, 0,   0,   0};
    vecs[6] = '{158, 119,   3,   2,  0,  0,     2,    10,     5, 3, 159, 119};
    vecs[7] = '{  0,   0,   1,   1,  0,  0,     1,     5,     0, 3,   0,   0};
    vecs[8] = '{ 60,  40,  40,  40,  0, 100, 1600,  1604,  1599, 3,  99,  79};

    bus.start = 1'b0; bus.black = 1'b0;
    bus.xOrigin = '0; bus.yOrigin = '0; bus.width = '0; bus.height = '0;
`ifdef TRANSPARENT_EN
    bus.colourKey = 3'd0;
`endif
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset romAddr", int'(bus.romAddr), 0);
    check("reset vgaX", int'(bus.vgaX), 0);
    check("reset vgaY", int'(bus.vgaY), 0);
    check("reset vgaColour", int'(bus.vgaColour), 0);
    check("reset plot", int'(bus.plot), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    resetn = 1'b1;

    romMode = 0;
    for (int i = 0; i < 9; i++) runDraw(vecs[i], 0, 0, $sformatf("vec%0d", i));

    // Reset in the middle of a sprite draw: outputs clear, no done follows.
    @(negedge clk);
    bus.xOrigin = 8'd60; bus.yOrigin = 7'd40; bus.width = 8'd40; bus.height = 7'd40;
    bus.black = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (500) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset plot", int'(bus.plot), 0);
    check("midreset busy", int'(bus.busy), 0);
    check("midreset done", int'(bus.done), 0);
    check("midreset vgaX", int'(bus.vgaX), 0);
    check("midreset vgaY", int'(bus.vgaY), 0);
    check("midreset vgaColour", int'(bus.vgaColour), 0);
    check("midreset romAddr", int'(bus.romAddr), 0);
    resetn = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done || bus.plot || bus.busy) seen++;
    end
    check("midreset quiet afterwards", seen, 0);

`ifdef TRANSPARENT_EN
    begin
      vec_t tv;
      romMode = 1;
      bus.colourKey = KEY_MAGENTA;
      tv = '{0, 0, 40, 40, 0, 0, 800, 1604, 1599, 4, 39, 39};
      runDraw(tv, 1, int'(KEY_MAGENTA), "transparent");
      tv = '{0, 0, 40, 40, 1, 0, 1600, 1604, 1599, 3, 39, 39};
      runDraw(tv, 1, int'(KEY_MAGENTA), "transparent black");
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_draw_engine.md
Name: sprite_draw_engine

Overview:
- Pixel-walking datapath stage directly downstream of the game controller FSM.
- On a start pulse it raster-scans a rectangle (full 160x120 screen or a 40x40 sprite) at a given origin.
- Each cycle it issues a linear ROM address and emits aligned VGA x/y/colour/plot to the VGA adapter.
- It raises done when finished, so the controller can leave its draw state without its own x/y/address counters.

Parameters:
- SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped.
- ADDR_W, 15, ROM address width (covers 19200 words).
- ROM_LAT, 1, ROM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; latches the geometry inputs and begins a draw
- black  in  1  sampled at start; when 1, colour is forced to 3'b000 (screen clear)
- xOrigin  in  8  top-left x
- yOrigin  in  7  top-left y
- width  in  8  rectangle width, 0..160
- height  in  7  rectangle height, 0..120
- romData  in  3  colour returned by the selected ROM
- romAddr  out  ADDR_W  linear read address, row-major from 0
- vgaX  out  8  pixel x
- vgaY  out  7  pixel y
- vgaColour  out  3  pixel colour
- plot  out  1  write strobe to the VGA adapter
- busy  out  1  high from the cycle after start until done
- done  out  1  single-cycle pulse after the last pixel is emitted

Behaviour:
- Reset, sampled on a clk edge with resetn=0: all outputs 0, FSM to IDLE, pipeline valid bits cleared. Reset mid-draw aborts the draw with no done pulse.
- FSM states: IDLE, SCAN, FLUSH, FIN.
- IDLE:
  - On start, latch origin, size and black; clear column/row counters and romAddr.
  - If width=0 or height=0, go to FIN; otherwise go to SCAN.
  - start outside IDLE is ignored.
- SCAN, one pixel per cycle:
  - romAddr = row*width + col, maintained incrementally (+1 per cycle, never a multiplier).
  - col increments; at col=width-1, col wraps to 0 and row increments.
  - After issuing col=width-1, row=height-1, go to FLUSH.
- Pipeline:
  - xOrigin+col and yOrigin+row, plus a valid bit, are delayed ROM_LAT cycles to align with romData.
  - Sums are computed at 9/8 bits before clipping, with no wrap-around.
  - Outputs are registered: plot = delayed valid AND x < SCREEN_W AND y < SCREEN_H.
  - vgaColour = black ? 0 : romData.
  - Total pixel latency is ROM_LAT+1 cycles from address to plot.
- FLUSH: wait ROM_LAT+1 cycles until the pipeline drains, then go to FIN.
- FIN: done=1 for exactly one cycle, then go to IDLE.
- busy is high in SCAN, FLUSH and FIN.
- A w x h draw with no start-to-start collision takes w*h + ROM_LAT + 3 cycles from start to done.
- vgaX, vgaY and vgaColour hold their last values when plot=0.

Optional Feature:
- Macro TRANSPARENT_EN.
- Defined:
  - Add input colourKey[2:0].
  - plot is suppressed for any pixel whose romData equals colourKey, unless black=1.
  - Address and timing are unchanged.
- Undefined:
  - No colourKey port.
  - Every in-bounds pixel plots.

Decomposition:
- Shared package draw_pkg holds:
  - SCREEN_W, SCREEN_H, the ADDR_W default and the sprite size 40;
  - colour constants BLACK=3'b000 and KEY_MAGENTA=3'b101;
  - a state typedef for IDLE/SCAN/FLUSH/FIN.
- One natural sub-module: draw_delay_line, a parameterised ROM_LAT-deep shift register carrying {valid, x, y}.

Test Plan:
- Full-screen draw: start, origin (0,0), 160x120, ROM_LAT=1, romData=addr[2:0]
  -> 19200 plots; first plot (0,0) colour 0; last plot (159,119) romAddr 19199; done exactly at cycle 19204.
- Sprite draw: origin (60,40), 40x40
  -> 1600 plots; pixel k at (60+k%40, 40+k/40); done once; busy low afterwards.
- Clipping: origin (150,100), 40x40
  -> plot only for x 150..159 and y 100..119 (200 plots); addresses still run 0..1599.
- Black and zero size:
  - black=1 on a 40x40 -> all vgaColour=0;
  - width=0 -> no plot, done 2 cycles after start.
- Disruption:
  - start pulsed during SCAN -> ignored, counts unaffected;
  - resetn=0 mid-draw -> next cycle all outputs 0, no done pulse.
- TRANSPARENT_EN with colourKey=5 and romData alternating 5/2
  -> exactly half of the pixels plot.
